// File: rtl/reaction_timer_fsm.sv
// Reaction-time game controller: random wait, stimulus LED, BCD response timing,
// best-time tracking, foul and timeout detection.
module reaction_timer_fsm #(
   parameter int          MIN_DELAY = 1000,
   parameter logic [15:0] MAX_BCD   = 16'h9999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick_1ms,
   input  logic        start,
   input  logic        react,
   input  logic [11:0] lfsr_delay,
   output logic        stim_led,
   output logic [15:0] time_bcd,
   output logic [15:0] best_bcd,
   output logic        busy,
   output logic        foul,
   output logic        timeout,
   output logic        new_best
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      ARMED = 3'd2,
      DONE  = 3'd3,
      FOUL  = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [12:0] wait_cnt, wait_nxt;
   logic [15:0] time_q, time_nxt;
   logic [15:0] best_q, best_nxt;
   logic        to_q, to_nxt;
   logic        nb_q, nb_nxt;

   // Ripple-carry increment over four BCD digits; 9 wraps to 0 and carries.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= 13'd0;
         time_q   <= 16'h0000;
         best_q   <= 16'h9999;
         to_q     <= 1'b0;
         nb_q     <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         time_q   <= time_nxt;
         best_q   <= best_nxt;
         to_q     <= to_nxt;
         nb_q     <= nb_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      time_nxt  = time_q;
      best_nxt  = best_q;
      to_nxt    = to_q;
      nb_nxt    = 1'b0;
      case (state)
         IDLE, DONE, FOUL: begin
            if (start) begin
               state_nxt = WAIT;
               wait_nxt  = {1'b0, lfsr_delay} + 13'(MIN_DELAY);
               time_nxt  = 16'h0000;
               to_nxt    = 1'b0;
            end
         end
         WAIT: begin
            // A press before the LED lights is a foul, even on the expiry tick.
            if (react) begin
               state_nxt = FOUL;
               time_nxt  = 16'h0000;
            end else if (tick_1ms) begin
               if (wait_cnt == 13'd1) state_nxt = ARMED;
               else                   wait_nxt  = wait_cnt - 13'd1;
            end
         end
         ARMED: begin
            if (react) begin
               state_nxt = DONE;
               if (time_q < best_q) begin
                  best_nxt = time_q;
                  nb_nxt   = 1'b1;
               end
            end else if (tick_1ms) begin
               if (time_q == MAX_BCD) begin
                  state_nxt = DONE;
                  to_nxt    = 1'b1;
               end else begin
                  time_nxt = bcd_inc(time_q);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stim_led = (state == ARMED);
   assign busy     = (state == WAIT) || (state == ARMED);
   assign foul     = (state == FOUL);
   assign timeout  = (state == DONE) && to_q;
   assign time_bcd = time_q;
   assign best_bcd = best_q;
   assign new_best = nb_q;

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Directed bench for reaction_timer_fsm with hand-computed expected values.
module tb_reaction_timer_fsm;

   logic        clk;
   logic        reset_n;
   logic        tick_1ms;
   logic        start;
   logic        react;
   logic [11:0] lfsr_delay;
   logic        stim_led;
   logic [15:0] time_bcd;
   logic [15:0] best_bcd;
   logic        busy;
   logic        foul;
   logic        timeout;
   logic        new_best;

   int checks = 0;
   int errors = 0;
   int bad_digits = 0;
   int led_seen = 0;

   reaction_timer_fsm dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_1ms   (tick_1ms),
      .start      (start),
      .react      (react),
      .lfsr_delay (lfsr_delay),
      .stim_led   (stim_led),
      .time_bcd   (time_bcd),
      .best_bcd   (best_bcd),
      .busy       (busy),
      .foul       (foul),
      .timeout    (timeout),
      .new_best   (new_best)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply inputs for one clk, then sample 1 time unit after the edge.
   task automatic cyc(input logic t, input logic s, input logic r);
      tick_1ms = t;
      start    = s;
      react    = r;
      @(posedge clk);
      #1;
      start = 1'b0;
      react = 1'b0;
      for (int i = 0; i < 4; i++)
         if (time_bcd[4*i +: 4] > 4'd9) bad_digits++;
      if (stim_led) led_seen++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
   endtask

   task automatic tick3();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      tick_1ms   = 1'b0;
      start      = 1'b0;
      react      = 1'b0;
      lfsr_delay = 12'h000;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic start_round(input logic [11:0] d);
      lfsr_delay = d;
      cyc(1'b1, 1'b1, 1'b0);
   endtask

   // Full round with a 1000-tick wait and a reaction after r ticks.
   task automatic play(input int r, input logic [15:0] t_exp, input logic [15:0] b_exp,
                       input logic nb_exp);
      start_round(12'h000);
      ticks(1000);
      ticks(r);
      cyc(1'b1, 1'b0, 1'b1);
      check("play_time", time_bcd, t_exp);
      check("play_best", best_bcd, b_exp);
      check("play_new_best", {15'd0, new_best}, {15'd0, nb_exp});
      cyc(1'b0, 1'b0, 1'b0);
      check("play_nb_clear", {15'd0, new_best}, 16'd0);
   endtask

   initial begin
      // Reset values
      do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_stim", {15'd0, stim_led}, 16'd0);
      check("rst_time", time_bcd, 16'h0000);
      check("rst_best", best_bcd, 16'h9999);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_foul", {15'd0, foul}, 16'd0);
      check("rst_timeout", {15'd0, timeout}, 16'd0);
      check("rst_new_best", {15'd0, new_best}, 16'd0);
      do_reset();

      // Basic round: wait of 1005 ticks, reaction of 237 ms
      cyc(1'b1, 1'b0, 1'b1);
      check("idle_react_ignored", {15'd0, busy}, 16'd0);
      start_round(12'h005);
      check("basic_busy", {15'd0, busy}, 16'd1);
      ticks(1004);
      check("basic_led_early", {15'd0, stim_led}, 16'd0);
      ticks(1);
      check("basic_led_on", {15'd0, stim_led}, 16'd1);
      ticks(237);
      check("basic_count", time_bcd, 16'h0237);
      cyc(1'b1, 1'b0, 1'b1);
      check("basic_time", time_bcd, 16'h0237);
      check("basic_best", best_bcd, 16'h0237);
      check("basic_new_best", {15'd0, new_best}, 16'd1);
      check("basic_busy_done", {15'd0, busy}, 16'd0);
      check("basic_led_off", {15'd0, stim_led}, 16'd0);
      cyc(1'b1, 1'b0, 1'b1);
      check("basic_nb_pulse", {15'd0, new_best}, 16'd0);
      check("basic_frozen", time_bcd, 16'h0237);

      // Foul at tick 500 of WAIT
      do_reset();
      start_round(12'h000);
      led_seen = 0;
      ticks(499);
      cyc(1'b1, 1'b0, 1'b1);
      check("foul_flag", {15'd0, foul}, 16'd1);
      check("foul_led_seen", led_seen[15:0], 16'd0);
      check("foul_best", best_bcd, 16'h9999);
      check("foul_time", time_bcd, 16'h0000);
      check("foul_busy", {15'd0, busy}, 16'd0);

      // React on the final WAIT tick
      start_round(12'h000);
      check("foul_cleared", {15'd0, foul}, 16'd0);
      ticks(999);
      cyc(1'b1, 1'b0, 1'b1);
      check("final_tick_foul", {15'd0, foul}, 16'd1);
      check("final_tick_led", {15'd0, stim_led}, 16'd0);

      // React together with a tick at 0041
      start_round(12'h000);
      ticks(1000);
      ticks(41);
      cyc(1'b1, 1'b0, 1'b1);
      check("simul_time", time_bcd, 16'h0041);
      check("simul_best", best_bcd, 16'h0041);

      // Timeout after 9999 ticks in ARMED
      start_round(12'h000);
      check("to_time_cleared", time_bcd, 16'h0000);
      ticks(1000);
      ticks(9999);
      check("to_at_max", time_bcd, 16'h9999);
      check("to_still_armed", {15'd0, stim_led}, 16'd1);
      check("to_not_yet", {15'd0, timeout}, 16'd0);
      ticks(1);
      check("to_flag", {15'd0, timeout}, 16'd1);
      check("to_time", time_bcd, 16'h9999);
      check("to_led", {15'd0, stim_led}, 16'd0);
      check("to_best", best_bcd, 16'h0041);
      check("to_new_best", {15'd0, new_best}, 16'd0);
      ticks(1);
      check("to_hold", time_bcd, 16'h9999);
      start_round(12'h000);
      check("to_cleared", {15'd0, timeout}, 16'd0);

      // Best tracking over 300, 250, 400 ms
      do_reset();
      play(300, 16'h0300, 16'h0300, 1'b1);
      play(250, 16'h0250, 16'h0250, 1'b1);
      play(400, 16'h0400, 16'h0250, 1'b0);

      // Asynchronous reset in the middle of ARMED
      start_round(12'h000);
      ticks(1000);
      ticks(123);
      check("mid_count", time_bcd, 16'h0123);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_stim", {15'd0, stim_led}, 16'd0);
      check("mid_time", time_bcd, 16'h0000);
      check("mid_best", best_bcd, 16'h9999);
      check("mid_busy", {15'd0, busy}, 16'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      play(100, 16'h0100, 16'h0100, 1'b1);

      // BCD carry with a tick every third clk
      start_round(12'h000);
      for (int i = 0; i < 1000; i++) tick3();
      check("bcd_armed", {15'd0, stim_led}, 16'd1);
      for (int i = 0; i < 99; i++) tick3();
      check("bcd_0099", time_bcd, 16'h0099);
      tick3();
      check("bcd_0100", time_bcd, 16'h0100);
      for (int i = 0; i < 899; i++) tick3();
      check("bcd_0999", time_bcd, 16'h0999);
      tick3();
      check("bcd_1000", time_bcd, 16'h1000);
      check("bcd_digits", bad_digits[15:0], 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
